// File: rtl/tag_rx_pkg.sv
// rtl/tag_rx_pkg.sv - shared state encoding, width helper and {I,Q} packing for the tag receive path
package tag_rx_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } state_t;

   // Packed result word: I occupies the upper half, Q the lower half
   localparam int IQ_I_HALF = 1;
   localparam int IQ_Q_HALF = 0;

   // Accumulator width that can hold nsig full-scale signed samples without overflow
   function automatic int acc_width(input int data_width, input int nsig);
      return data_width + $clog2(nsig) + 1;
   endfunction

endpackage

// File: rtl/tag_rx_iq_accum.sv
// rtl/tag_rx_iq_accum.sv - paired signed I/Q accumulator with clear, enable and dump-and-restart
module tag_rx_iq_accum #(
   parameter int IN_W  = 16,
   parameter int ACC_W = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             restart,
   input  logic [IN_W-1:0]  i_in,
   input  logic [IN_W-1:0]  q_in,
   output logic [ACC_W-1:0] sum_i,
   output logic [ACC_W-1:0] sum_q
);

   logic signed [ACC_W-1:0] acc_i_q, acc_i_d;
   logic signed [ACC_W-1:0] acc_q_q, acc_q_d;
   logic signed [ACC_W-1:0] i_ext, q_ext;
   logic signed [ACC_W-1:0] add_i, add_q;

   assign i_ext = {{(ACC_W-IN_W){i_in[IN_W-1]}}, i_in};
   assign q_ext = {{(ACC_W-IN_W){q_in[IN_W-1]}}, q_in};
   assign add_i = acc_i_q + i_ext;
   assign add_q = acc_q_q + q_ext;

   // Running sum including the current sample; this is the value dumped at window close
   assign sum_i = add_i;
   assign sum_q = add_q;

   // Clear beats everything so a frame restart discards the sample; dump restarts from zero
   always_comb begin
      acc_i_d = acc_i_q;
      acc_q_d = acc_q_q;
      if (clr) begin
         acc_i_d = '0;
         acc_q_d = '0;
      end else if (en) begin
         acc_i_d = restart ? '0 : add_i;
         acc_q_d = restart ? '0 : add_q;
      end
   end

   // Accumulator registers
   always_ff @(posedge clk) begin
      if (reset) begin
         acc_i_q <= '0;
         acc_q_q <= '0;
      end else begin
         acc_i_q <= acc_i_d;
         acc_q_q <= acc_q_d;
      end
   end

endmodule

// File: rtl/tag_rx_win_accum.sv
// rtl/tag_rx_win_accum.sv - per-location windowed I/Q summation after each sync, with valid/ready output
module tag_rx_win_accum
   import tag_rx_pkg::*;
#(
   parameter  int DATA_WIDTH    = 16,
   parameter  int NSIG          = 262144,
   parameter  int NLOC_PER_SYNC = 3,
   localparam int ACC_WIDTH     = acc_width(DATA_WIDTH, NSIG),
   localparam int LOC_W         = $clog2(NLOC_PER_SYNC + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   rx_valid,
   input  logic [DATA_WIDTH-1:0]  irx_in,
   input  logic [DATA_WIDTH-1:0]  qrx_in,
   input  logic                   sync_stb,
   output logic [2*ACC_WIDTH-1:0] o_tdata,
   output logic [LOC_W-1:0]       o_loc,
   output logic                   o_tlast,
   output logic                   o_tvalid,
   input  logic                   o_tready,
   output logic                   overrun,
   output logic                   resync,
   output logic                   busy
);

   localparam int               CNT_W    = $clog2(NSIG);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSIG - 1);
   localparam logic [LOC_W-1:0] LOC_LAST = LOC_W'(NLOC_PER_SYNC - 1);

   state_t                 state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [LOC_W-1:0]       loc_q, loc_d;
   logic                   o_tvalid_q, o_tvalid_d;
   logic [2*ACC_WIDTH-1:0] o_tdata_q, o_tdata_d;
   logic [LOC_W-1:0]       o_loc_q, o_loc_d;
   logic                   o_tlast_q, o_tlast_d;
   logic                   overrun_q, overrun_d;
   logic                   resync_q, resync_d;

   logic                   accept, close, last_close;
   logic [ACC_WIDTH-1:0]   sum_i, sum_q;

   // Samples count only while a frame is open; the sync cycle itself never contributes
   assign accept     = (state_q == ST_ACC) && rx_valid;
   assign close      = accept && (cnt_q == CNT_LAST);
   assign last_close = close && (loc_q == LOC_LAST);

   tag_rx_iq_accum #(
      .IN_W  (DATA_WIDTH),
      .ACC_W (ACC_WIDTH)
   ) u_iq_accum (
      .clk     (clk),
      .reset   (reset),
      .clr     (sync_stb),
      .en      (accept),
      .restart (close),
      .i_in    (irx_in),
      .q_in    (qrx_in),
      .sum_i   (sum_i),
      .sum_q   (sum_q)
   );

   // Frame FSM and counters; a sync applies after any coincident window close
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      loc_d    = loc_q;
      resync_d = resync_q;
      if (accept) begin
         if (close) begin
            cnt_d = '0;
            loc_d = loc_q + 1'b1;
            if (last_close) begin
               state_d = ST_IDLE;
            end
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
      if (sync_stb) begin
         if (state_q == ST_ACC) begin
            resync_d = 1'b1;
         end
         state_d = ST_ACC;
         cnt_d   = '0;
         loc_d   = '0;
      end
   end

   // Single-entry output register; a result arriving while the held one is stalled is dropped
   always_comb begin
      o_tvalid_d = o_tvalid_q;
      o_tdata_d  = o_tdata_q;
      o_loc_d    = o_loc_q;
      o_tlast_d  = o_tlast_q;
      overrun_d  = overrun_q;
      if (close) begin
         if (o_tvalid_q && !o_tready) begin
            overrun_d = 1'b1;
         end else begin
            o_tvalid_d = 1'b1;
            o_tdata_d[IQ_I_HALF*ACC_WIDTH +: ACC_WIDTH] = sum_i;
            o_tdata_d[IQ_Q_HALF*ACC_WIDTH +: ACC_WIDTH] = sum_q;
            o_loc_d    = loc_q;
            o_tlast_d  = last_close;
         end
      end else if (o_tvalid_q && o_tready) begin
         o_tvalid_d = 1'b0;
      end
   end

   // State, counter and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         loc_q      <= '0;
         o_tvalid_q <= 1'b0;
         o_tdata_q  <= '0;
         o_loc_q    <= '0;
         o_tlast_q  <= 1'b0;
         overrun_q  <= 1'b0;
         resync_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         loc_q      <= loc_d;
         o_tvalid_q <= o_tvalid_d;
         o_tdata_q  <= o_tdata_d;
         o_loc_q    <= o_loc_d;
         o_tlast_q  <= o_tlast_d;
         overrun_q  <= overrun_d;
         resync_q   <= resync_d;
      end
   end

   assign o_tvalid = o_tvalid_q;
   assign o_tdata  = o_tdata_q;
   assign o_loc    = o_loc_q;
   assign o_tlast  = o_tlast_q;
   assign overrun  = overrun_q;
   assign resync   = resync_q;
   assign busy     = (state_q == ST_ACC);

endmodule

// File: tb/tb_tag_rx_win_accum.sv
// tb/tb_tag_rx_win_accum.sv - scoreboard bench for tag_rx_win_accum with NSIG=4, three locations
module tb_tag_rx_win_accum;

   localparam int DW    = 16;
   localparam int NSIG  = 4;
   localparam int NLOC  = 3;
   localparam int ACC_W = 19;
   localparam int LOC_W = 2;

   logic               clk = 1'b0;
   logic               reset;
   logic               rx_valid;
   logic [DW-1:0]      irx_in, qrx_in;
   logic               sync_stb;
   logic [2*ACC_W-1:0] o_tdata;
   logic [LOC_W-1:0]   o_loc;
   logic               o_tlast, o_tvalid, o_tready;
   logic               overrun, resync, busy;

   typedef struct {
      logic [2*ACC_W-1:0] tdata;
      logic [LOC_W-1:0]   loc;
      logic               tlast;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   int total = 0;
   int bad   = 0;
   int n_rx  = 0;
   int n_before;

   logic signed [ACC_W-1:0] last_i, last_q;
   logic [LOC_W-1:0]        last_loc;
   logic                    last_tlast;
   logic [2*ACC_W-1:0]      held0;

   // reference model state
   bit                      m_acc, m_ov;
   int                      m_cnt, m_loc;
   logic signed [ACC_W-1:0] m_ai, m_aq, m_si, m_sq;

   tag_rx_win_accum #(
      .DATA_WIDTH    (DW),
      .NSIG          (NSIG),
      .NLOC_PER_SYNC (NLOC)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .rx_valid (rx_valid),
      .irx_in   (irx_in),
      .qrx_in   (qrx_in),
      .sync_stb (sync_stb),
      .o_tdata  (o_tdata),
      .o_loc    (o_loc),
      .o_tlast  (o_tlast),
      .o_tvalid (o_tvalid),
      .o_tready (o_tready),
      .overrun  (overrun),
      .resync   (resync),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_ov = 0; m_cnt = 0; m_loc = 0; m_ai = '0; m_aq = '0;
   endtask

   // Advance the reference model by the inputs currently applied
   task automatic model_step();
      exp_t e;
      bit   acc_s, close_s;
      acc_s   = m_acc && rx_valid;
      close_s = acc_s && (m_cnt == NSIG - 1);
      m_si = m_ai + $signed(irx_in);
      m_sq = m_aq + $signed(qrx_in);
      if (close_s) begin
         if (m_ov && !o_tready) begin
            // dropped
         end else begin
            e.tdata = {m_si, m_sq};
            e.loc   = LOC_W'(m_loc);
            e.tlast = (m_loc == NLOC - 1);
            sb_q.push_back(e);
            m_ov = 1;
         end
      end else if (m_ov && o_tready) begin
         m_ov = 0;
      end
      if (acc_s) begin
         if (close_s) begin
            m_ai = '0; m_aq = '0; m_cnt = 0;
            if (m_loc == NLOC - 1) m_acc = 0;
            m_loc++;
         end else begin
            m_ai = m_si; m_aq = m_sq; m_cnt++;
         end
      end
      if (sync_stb) begin
         m_acc = 1; m_cnt = 0; m_loc = 0; m_ai = '0; m_aq = '0;
      end
   endtask

   task automatic cycle(input logic v, input logic [DW-1:0] i, input logic [DW-1:0] q, input logic s);
      rx_valid = v; irx_in = i; qrx_in = q; sync_stb = s;
      model_step();
      @(posedge clk);
      #1;
      rx_valid = 1'b0; sync_stb = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 20 && sb_q.size() != 0; k++) cycle(1'b0, '0, '0, 1'b0);
      chk("drain", 64'(sb_q.size()), 64'd0);
      cycle(1'b0, '0, '0, 1'b0);
   endtask

   // Scoreboard: compare every transfer against the oldest expected result
   always @(negedge clk) begin
      if (!reset && o_tvalid && o_tready) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_out", 64'd1, 64'd0);
         end else begin
            mon_e = sb_q.pop_front();
            chk("tdata", 64'(o_tdata), 64'(mon_e.tdata));
            chk("loc", 64'(o_loc), 64'(mon_e.loc));
            chk("tlast", 64'(o_tlast), 64'(mon_e.tlast));
         end
         last_i     = o_tdata[2*ACC_W-1:ACC_W];
         last_q     = o_tdata[ACC_W-1:0];
         last_loc   = o_loc;
         last_tlast = o_tlast;
         n_rx++;
      end
   end

   initial begin
      reset = 1'b1; rx_valid = 1'b0; irx_in = '0; qrx_in = '0; sync_stb = 1'b0; o_tready = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      chk("rst_tvalid", 64'(o_tvalid), 64'd0);
      chk("rst_tdata", 64'(o_tdata), 64'd0);
      chk("rst_loc", 64'(o_loc), 64'd0);
      chk("rst_tlast", 64'(o_tlast), 64'd0);
      chk("rst_overrun", 64'(overrun), 64'd0);
      chk("rst_resync", 64'(resync), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);

      // 1: basic frame
      n_before = n_rx;
      cycle(1'b0, '0, '0, 1'b1);
      chk("t1_busy_on", 64'(busy), 64'd1);
      for (int j = 0; j < 12; j++) cycle(1'b1, 16'sd1, -16'sd2, 1'b0);
      chk("t1_busy_off", 64'(busy), 64'd0);
      drain();
      chk("t1_count", 64'(n_rx - n_before), 64'd3);
      chk("t1_i", 64'(last_i), 64'd4);
      chk("t1_q", 64'(last_q), 64'(-8));
      chk("t1_lastloc", 64'(last_loc), 64'd2);
      chk("t1_tlast", 64'(last_tlast), 64'd1);

      // 2: toggling rx_valid, one-cycle latency
      n_before = n_rx;
      cycle(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 12; j++) begin
         cycle(1'b1, 16'sd1, -16'sd2, 1'b0);
         if (j % 4 == 2) chk("t2_pre_valid", 64'(o_tvalid), 64'd0);
         if (j % 4 == 3) begin
            chk("t2_lat_valid", 64'(o_tvalid), 64'd1);
            chk("t2_lat_loc", 64'(o_loc), 64'(j / 4));
         end
         cycle(1'b0, 16'sd5, 16'sd5, 1'b0);
      end
      drain();
      chk("t2_count", 64'(n_rx - n_before), 64'd3);

      // 3: full-scale samples, no wrap
      n_before = n_rx;
      cycle(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 12; j++) cycle(1'b1, 16'h7FFF, 16'h8000, 1'b0);
      drain();
      chk("t3_count", 64'(n_rx - n_before), 64'd3);
      chk("t3_i", 64'(last_i), 64'd131068);
      chk("t3_q", 64'(last_q), 64'(-131072));

      // 4: sync mid-frame
      n_before = n_rx;
      cycle(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 6; j++) cycle(1'b1, 16'sd1, -16'sd2, 1'b0);
      chk("t4_no_resync_yet", 64'(resync), 64'd0);
      cycle(1'b0, '0, '0, 1'b1);
      chk("t4_resync", 64'(resync), 64'd1);
      for (int j = 0; j < 12; j++) cycle(1'b1, 16'sd1, -16'sd2, 1'b0);
      drain();
      chk("t4_count", 64'(n_rx - n_before), 64'd4);
      chk("t4_i", 64'(last_i), 64'd4);
      chk("t4_busy", 64'(busy), 64'd0);

      // 5: stalled consumer
      n_before = n_rx;
      o_tready = 1'b0;
      cycle(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 12; j++) begin
         cycle(1'b1, 16'(j + 1), 16'(j), 1'b0);
         if (j == 3) held0 = o_tdata;
      end
      chk("t5_valid", 64'(o_tvalid), 64'd1);
      chk("t5_loc", 64'(o_loc), 64'd0);
      chk("t5_held", 64'(o_tdata), 64'(held0));
      chk("t5_held_i", 64'(held0[2*ACC_W-1:ACC_W]), 64'd10);
      chk("t5_overrun", 64'(overrun), 64'd1);
      chk("t5_sb_depth", 64'(sb_q.size()), 64'd1);
      o_tready = 1'b1;
      drain();
      repeat (3) cycle(1'b0, '0, '0, 1'b0);
      chk("t5_count", 64'(n_rx - n_before), 64'd1);
      chk("t5_valid_off", 64'(o_tvalid), 64'd0);

      // 6: reset mid-window
      n_before = n_rx;
      cycle(1'b0, '0, '0, 1'b1);
      for (int j = 0; j < 2; j++) cycle(1'b1, 16'sd3, 16'sd3, 1'b0);
      reset = 1'b1;
      model_reset();
      @(posedge clk);
      #1;
      reset = 1'b0;
      chk("t6_tvalid", 64'(o_tvalid), 64'd0);
      chk("t6_tdata", 64'(o_tdata), 64'd0);
      chk("t6_loc", 64'(o_loc), 64'd0);
      chk("t6_tlast", 64'(o_tlast), 64'd0);
      chk("t6_overrun", 64'(overrun), 64'd0);
      chk("t6_resync", 64'(resync), 64'd0);
      chk("t6_busy", 64'(busy), 64'd0);
      for (int j = 0; j < 8; j++) cycle(1'b1, 16'sd1, 16'sd1, 1'b0);
      repeat (3) cycle(1'b0, '0, '0, 1'b0);
      chk("t6_no_output", 64'(n_rx - n_before), 64'd0);
      chk("t6_sb_empty", 64'(sb_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
